// File: rtl/reg_file.sv
// CPU general-purpose register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Packed so each slice can be owned by its own generate branch without multi-driver issues.
    logic [DEPTH-1:0][DATA_W-1:0] regs;

    assign regs[0] = '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
            localparam logic [DATA_W-1:0] RESET_VAL =
                (gi == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    q_reg <= RESET_VAL;
                end else if (reg_write_i && (rd_addr_i == ADDR_W'(gi))) begin
                    q_reg <= rd_data_i;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    logic [DATA_W-1:0] rs_array;
    logic [DATA_W-1:0] rt_array;

    assign rs_array = regs[rs_addr_i];
    assign rt_array = regs[rt_addr_i];

`ifdef REG_FILE_BYPASS_EN
    logic write_live;
    logic rs_fwd;
    logic rt_fwd;

    // A pending write to r0, or any write while in reset, never forwards.
    assign write_live = rst_i && reg_write_i && (rd_addr_i != '0);
    assign rs_fwd     = write_live && (rd_addr_i == rs_addr_i);
    assign rt_fwd     = write_live && (rd_addr_i == rt_addr_i);

    assign rs_data_o = rs_fwd ? rd_data_i : rs_array;
    assign rt_data_o = rt_fwd ? rd_data_i : rt_array;
`else
    assign rs_data_o = rs_array;
    assign rt_data_o = rt_array;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; define REG_FILE_BYPASS_EN to match a forwarding build.
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              reg_write;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    int checks_reg = 0;
    int errors_reg = 0;

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .SP_IDX (29),
        .SP_INIT(128)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .rs_addr_i  (rs_addr),
        .rt_addr_i  (rt_addr),
        .rd_addr_i  (rd_addr),
        .rd_data_i  (rd_data),
        .reg_write_i(reg_write),
        .rs_data_o  (rs_data),
        .rt_data_o  (rt_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks_reg++;
        if (got !== exp) begin
            errors_reg++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%08h", tag, got);
        end
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rd_addr   = a;
        rd_data   = d;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    task automatic read_both(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [ADDR_W-1:0] b,
                             input logic [DATA_W-1:0] exp_a,
                             input logic [DATA_W-1:0] exp_b);
        rs_addr = a;
        rt_addr = b;
        #1;
        check($sformatf("%s rs[%0d]", tag, a), rs_data, exp_a);
        check($sformatf("%s rt[%0d]", tag, b), rt_data, exp_b);
    endtask

    function automatic logic [DATA_W-1:0] reset_val(input int idx);
        return (idx == 29) ? 32'd128 : 32'd0;
    endfunction

    initial begin
        logic [DATA_W-1:0] exp_pre;

        rst_n     = 1'b1;
        rs_addr   = '0;
        rt_addr   = '0;
        rd_addr   = '0;
        rd_data   = '0;
        reg_write = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_both("rst", ADDR_W'(i), ADDR_W'(31 - i), reset_val(i), reset_val(31 - i));
        end

        // Writes while in reset are ignored.
        @(negedge clk);
        rd_addr = 5'd6; rd_data = 32'hCAFE_0006; reg_write = 1'b1;
        @(posedge clk); #1;
        read_both("wr_in_rst", 5'd6, 5'd29, 32'd0, 32'd128);

        // Reset released at the same time as a write to r4: the next edge commits it.
        @(negedge clk);
        rst_n = 1'b1; rd_addr = 5'd4; rd_data = 32'h0000_0077; reg_write = 1'b1;
        rs_addr = 5'd4; #1;
        check("rel_pre r4", rs_data,
`ifdef REG_FILE_BYPASS_EN
              32'h0000_0077);
`else
              32'd0);
`endif
        @(posedge clk); #1;
        reg_write = 1'b0;
        read_both("rel_post", 5'd4, 5'd6, 32'h77, 32'd0);

        write_reg(5'd5, 32'hDEAD_BEEF);
        read_both("wr_r5", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        read_both("cross", 5'd29, 5'd5, 32'd128, 32'hDEAD_BEEF);

        write_reg(5'd0, 32'hFFFF_FFFF);
        read_both("wr_r0", 5'd0, 5'd0, 32'd0, 32'd0);

        // Write enable low: three edges with rd_addr=7 change nothing.
        @(negedge clk);
        rd_addr = 5'd7; rd_data = 32'h0000_1234; reg_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        read_both("we0_r7", 5'd7, 5'd5, 32'd0, 32'hDEAD_BEEF);

        // Read-during-write on r9.
        write_reg(5'd9, 32'h0000_0011);
        @(negedge clk);
        rd_addr = 5'd9; rd_data = 32'h0000_0055; reg_write = 1'b1;
        rs_addr = 5'd9; rt_addr = 5'd5;
`ifdef REG_FILE_BYPASS_EN
        exp_pre = 32'h0000_0055;
`else
        exp_pre = 32'h0000_0011;
`endif
        #1;
        check("rdw_pre rs[9]", rs_data, exp_pre);
        check("rdw_pre rt[5]", rt_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        reg_write = 1'b0;
        read_both("rdw_post", 5'd9, 5'd9, 32'h55, 32'h55);

        // Fill r1..r31 with their index.
        for (int i = 1; i < 32; i++) begin
            write_reg(ADDR_W'(i), DATA_W'(i));
        end
        read_both("fill", 5'd17, 5'd29, 32'd17, 32'd29);
        read_both("fill", 5'd31, 5'd1, 32'd31, 32'd1);

        // 1 ns reset pulse mid-cycle.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            read_both("pulse", ADDR_W'(i), ADDR_W'(i), reset_val(i), reset_val(i));
        end

        write_reg(5'd3, 32'h0000_000A);
        read_both("post_pulse", 5'd3, 5'd2, 32'hA, 32'd0);
        read_both("post_pulse", 5'd29, 5'd4, 32'd128, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
